// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the AXI round-robin arbiters.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } arb_state_e;

    localparam int unsigned DEF_NUM_MASTERS    = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational rotate-priority encoder: the first set request after last_idx wins.
module axi_rr_picker
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_idx,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [IDX_W-1:0]       idx,
    output logic                   any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = IDX_W'((32'(last_idx) + 32'd1 + i) % NUM_MASTERS);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter_rr.sv
// Round-robin write-path arbiter: grant held for one full AW + W burst + B transaction.
// Optional stall watchdog enabled by defining AXI_WARB_TIMEOUT_EN.
module axi_wr_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int unsigned IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_MASTERS-1:0] req_awvalid,
    input  logic                   slv_awready,
    input  logic                   slv_awvalid,
    input  logic                   slv_wvalid,
    input  logic                   slv_wready,
    input  logic                   slv_wlast,
    input  logic                   slv_bvalid,
    input  logic                   slv_bready,
    output logic [NUM_MASTERS-1:0] wgrnt,
    output logic [IDX_W-1:0]       grnt_idx,
    output logic                   grnt_valid,
    output logic                   timeout_err
);

    arb_state_e state, state_d;
    logic [IDX_W-1:0]       last_q;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   aw_hs, w_last_hs, b_hs;
    logic                   rel, grant_new, tmo_fire;

    assign aw_hs     = slv_awvalid & slv_awready;
    assign w_last_hs = slv_wvalid & slv_wready & slv_wlast;
    assign b_hs      = slv_bvalid & slv_bready;

    axi_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req      (req_awvalid),
        .last_idx (last_q),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d   = state;
        rel       = 1'b0;
        grant_new = 1'b0;
        unique case (state)
            IDLE: if (pick_any) state_d = ADDR;
            ADDR: begin
                if (aw_hs && w_last_hs) state_d = RESP;
                else if (aw_hs)         state_d = DATA;
            end
            DATA: if (w_last_hs) state_d = RESP;
            RESP: if (b_hs) rel = 1'b1;
            default: state_d = IDLE;
        endcase
        if (tmo_fire) rel = 1'b1;
        // Any release re-arbitrates in the same cycle, so back-to-back grants need no idle cycle.
        if (rel) state_d = pick_any ? ADDR : IDLE;
        grant_new = pick_any && (state == IDLE || rel);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            last_q     <= IDX_W'(NUM_MASTERS - 1);
            wgrnt      <= '0;
            grnt_idx   <= '0;
            grnt_valid <= 1'b0;
        end else begin
            state      <= state_d;
            grnt_valid <= (state_d != IDLE);
            if (grant_new) begin
                wgrnt    <= pick_onehot;
                grnt_idx <= pick_idx;
                last_q   <= pick_idx;
            end else if (rel) begin
                wgrnt    <= '0;
                grnt_idx <= '0;
            end
        end
    end

`ifdef AXI_WARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             progress;

    assign progress = aw_hs | (slv_wvalid & slv_wready) | b_hs;
    assign tmo_fire = (state != IDLE) && !progress &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
            if (state == IDLE || progress || tmo_fire) tmo_cnt <= '0;
            else                                       tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// Self-checking bench for axi_wr_arbiter_rr against a transaction-level reference model.
module tb_axi_wr_arbiter_rr;

    localparam int N = 4;
    localparam int T = 16;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [N-1:0] req_awvalid = '0;
    logic         slv_awready = 1'b0, slv_awvalid = 1'b0;
    logic         slv_wvalid = 1'b0, slv_wready = 1'b0, slv_wlast = 1'b0;
    logic         slv_bvalid = 1'b0, slv_bready = 1'b0;
    logic [N-1:0] wgrnt;
    logic [1:0]   grnt_idx;
    logic         grnt_valid, timeout_err;

    axi_wr_arbiter_rr #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req_awvalid (req_awvalid),
        .slv_awready (slv_awready),
        .slv_awvalid (slv_awvalid),
        .slv_wvalid  (slv_wvalid),
        .slv_wready  (slv_wready),
        .slv_wlast   (slv_wlast),
        .slv_bvalid  (slv_bvalid),
        .slv_bready  (slv_bready),
        .wgrnt       (wgrnt),
        .grnt_idx    (grnt_idx),
        .grnt_valid  (grnt_valid),
        .timeout_err (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Reference model: owner of the current write (-1 = none) and its progress flags.
    int m_owner = -1, m_last = N - 1, m_beat = 0, m_cnt = 0;
    bit m_aw = 0, m_w = 0, m_tmo = 0, m_newg = 0;
    int gq[$];

    // Slave/master behaviour knobs.
    bit rand_mode = 0, stall_aw = 0, stall_w = 0;
    int beats = 2;

    task automatic ck(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update();
        bit aw_hs, wl_hs, w_hs, b_hs, rel;
        int c;
        aw_hs = slv_awvalid & slv_awready;
        w_hs  = slv_wvalid & slv_wready;
        wl_hs = w_hs & slv_wlast;
        b_hs  = slv_bvalid & slv_bready;
        rel    = 0;
        m_tmo  = 0;
        m_newg = 0;
        if (ARESET) begin
            m_owner = -1; m_last = N - 1; m_aw = 0; m_w = 0; m_cnt = 0;
            return;
        end
        if (m_owner >= 0) begin
            if (!m_aw) begin
                if (aw_hs) begin
                    m_aw = 1;
                    if (wl_hs) m_w = 1;
                end
            end else if (!m_w) begin
                if (wl_hs) m_w = 1;
            end else if (b_hs) begin
                rel = 1;
            end
            if (w_hs) m_beat++;
`ifdef AXI_WARB_TIMEOUT_EN
            if (aw_hs || w_hs || b_hs) m_cnt = 0;
            else if (m_cnt == T - 1) begin
                rel = 1; m_tmo = 1; m_cnt = 0;
            end else m_cnt++;
`endif
            if (rel) begin
                m_owner = -1; m_aw = 0; m_w = 0;
            end
        end
        if (m_owner < 0) begin
            c = rr_pick(m_last, req_awvalid);
            if (c >= 0) begin
                m_owner = c; m_last = c; m_aw = 0; m_w = 0; m_beat = 0; m_cnt = 0; m_newg = 1;
            end
        end
    endtask

    task automatic drive();
        bit awv, wv;
        if (rand_mode) begin
            slv_awvalid = 1'($urandom_range(0, 1));
            slv_awready = 1'($urandom_range(0, 1));
            slv_wvalid  = 1'($urandom_range(0, 1));
            slv_wready  = 1'($urandom_range(0, 1));
            slv_wlast   = ($urandom_range(0, 2) == 0);
            slv_bvalid  = 1'($urandom_range(0, 1));
            slv_bready  = 1'($urandom_range(0, 1));
        end else begin
            awv = (m_owner >= 0) && !m_aw && !stall_aw;
            wv  = (m_owner >= 0) && !m_w && (m_aw || (awv && beats == 1)) && !stall_w;
            slv_awvalid = awv;
            slv_awready = awv;
            slv_wvalid  = wv;
            slv_wready  = wv;
            slv_wlast   = wv && (m_beat == beats - 1);
            slv_bvalid  = (m_owner >= 0) && m_aw && m_w;
            slv_bready  = slv_bvalid;
        end
    endtask

    task automatic compare();
        ck("wgrnt", int'(wgrnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        ck("grnt_idx", int'(grnt_idx), (m_owner >= 0) ? m_owner : 0);
        ck("grnt_valid", int'(grnt_valid), int'(m_owner >= 0));
        ck("timeout_err", int'(timeout_err), int'(m_tmo));
        if (m_newg) gq.push_back(int'(grnt_idx));
    endtask

    task automatic step();
        @(posedge ACLK);
        model_update();
        #1;
        drive();
        @(negedge ACLK);
        compare();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
    endtask

    task automatic wait_grants(input int n, input string name);
        for (int i = 0; i < 300 && gq.size() < n; i++) step();
        ck(name, int'(gq.size() >= n), 1);
    endtask

    function automatic int gq_at(input int k);
        return (gq.size() > k) ? gq[k] : -1;
    endfunction

    int tmo_seen, tmo_at;

    initial begin
        @(negedge ACLK);
        step();
        step();
        ck("rst_wgrnt", int'(wgrnt), 0);
        ck("rst_idx", int'(grnt_idx), 0);
        ck("rst_valid", int'(grnt_valid), 0);
        ck("rst_tmo", int'(timeout_err), 0);
        ARESET = 1'b0;

        // Two requesters, 2-beat bursts: alternate m0, m2, m0.
        req_awvalid = 4'b0101;
        beats = 2;
        gq.delete();
        step();
        ck("a_first_grant", int'(wgrnt), 1);
        wait_grants(3, "a_count");
        ck("a_order0", gq_at(0), 0);
        ck("a_order1", gq_at(1), 2);
        ck("a_order2", gq_at(2), 0);

        // All requesting, 4-beat bursts.
        do_reset();
        req_awvalid = 4'b1111;
        beats = 4;
        gq.delete();
        wait_grants(5, "b_count");
        for (int k = 0; k < 5; k++) ck("b_order", gq_at(k), k % 4);

        // Single-beat burst: AW and last W together, grant held through B.
        do_reset();
        req_awvalid = 4'b0001;
        beats = 1;
        step();
        req_awvalid = 4'b0000;
        step();
        ck("c_held_resp", int'(wgrnt), 1);
        step();
        ck("c_released", int'(grnt_valid), 0);

        // Granted master drops its request in ADDR while m3 requests.
        do_reset();
        req_awvalid = 4'b0001;
        beats = 2;
        stall_aw = 1;
        step();
        req_awvalid = 4'b1000;
        repeat (5) step();
        ck("d_hold_idx", int'(grnt_idx), 0);
        ck("d_hold_grnt", int'(wgrnt), 1);
        stall_aw = 0;
        gq.delete();
        wait_grants(1, "d_count");
        ck("d_next", gq_at(0), 3);

        // W stalled after AW: watchdog release only when enabled.
        do_reset();
        req_awvalid = 4'b0011;
        beats = 4;
        stall_w = 1;
        step();
        for (int i = 0; i < 20 && !m_aw; i++) step();
        ck("e_aw_done", int'(m_aw), 1);
        gq.delete();
        tmo_seen = 0;
        tmo_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (timeout_err) begin
                tmo_seen++;
                if (tmo_at < 0) tmo_at = i;
            end
        end
`ifdef AXI_WARB_TIMEOUT_EN
        ck("e_tmo_pulses", tmo_seen, 1);
        ck("e_tmo_when", tmo_at, 16);
        ck("e_next_grant", gq_at(0), 1);
`else
        ck("e_tmo_pulses", tmo_seen, 0);
        ck("e_still_granted", int'(wgrnt), 1);
        ck("e_no_regrant", gq.size(), 0);
`endif
        stall_w = 0;
        repeat (20) step();

        // Reset during DATA.
        do_reset();
        req_awvalid = 4'b1111;
        beats = 4;
        step();
        step();
        ck("f_in_data", int'(m_aw && !m_w), 1);
        ARESET = 1'b1;
        step();
        ck("f_rst_grnt", int'(wgrnt), 0);
        ARESET = 1'b0;
        step();
        ck("f_first_grnt", int'(wgrnt), 1);

        // Randomised traffic against the model.
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req_awvalid = 4'($urandom);
            ARESET = ($urandom_range(0, 199) == 0);
            step();
        end
        ARESET = 1'b0;
        rand_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
